// File: rtl/cc_xor_stream.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// cc_xor_stream
//
// ChaCha20 keystream consumer. Sequences a cc_block core one 512-bit block at
// a time, holds the returned keystream block, and XORs it word by word onto a
// 32-bit message stream. Encryption and decryption are the same operation.
// When all 16 words of a block have been used and the message continues, the
// next block is requested with the block counter advanced by one.
//
// Parameters
//   P_CNT_LIMIT   last legal block counter; a request beyond it raises o_err
//
// Ports
//   i_clk         clock
//   i_rst         synchronous reset, active-high
//   i_init        start of message; latches i_key / i_non / i_cnt in IDLE
//   i_key[255:0]  key, word k = i_key[32k+31:32k]
//   i_non[95:0]   nonce, word k = i_non[32k+31:32k]
//   i_cnt[31:0]   initial block counter
//   i_valid       message word valid
//   i_data[31:0]  message word, little-endian bytes
//   i_keep[3:0]   byte enables (partial only on the last word)
//   i_last        last word of the message
//   o_ready       message word taken when i_valid & o_ready
//   o_valid       output word valid
//   o_data[31:0]  i_data ^ keystream word, disabled bytes forced to zero
//   o_keep[3:0]   registered i_keep
//   o_last        registered i_last
//   i_out_ready   downstream takes the output word
//   o_blk_start   one-cycle start pulse to cc_block
//   o_blk_key     latched key to cc_block
//   o_blk_non     latched nonce to cc_block
//   o_blk_cnt     current block counter to cc_block
//   i_blk_stream  cc_block keystream block
//   i_blk_done    cc_block done pulse; i_blk_stream valid in that cycle
//   o_busy        high whenever the controller is not IDLE
//   o_err         sticky counter-overflow flag, cleared only by i_rst
// ----------------------------------------------------------------------------
module cc_xor_stream #(
  parameter logic [31:0] P_CNT_LIMIT = 32'hFFFF_FFFF
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_init,
  input  logic [255:0] i_key,
  input  logic [95:0]  i_non,
  input  logic [31:0]  i_cnt,
  input  logic         i_valid,
  input  logic [31:0]  i_data,
  input  logic [3:0]   i_keep,
  input  logic         i_last,
  output logic         o_ready,
  output logic         o_valid,
  output logic [31:0]  o_data,
  output logic [3:0]   o_keep,
  output logic         o_last,
  input  logic         i_out_ready,
  output logic         o_blk_start,
  output logic [255:0] o_blk_key,
  output logic [95:0]  o_blk_non,
  output logic [31:0]  o_blk_cnt,
  input  logic [511:0] i_blk_stream,
  input  logic         i_blk_done,
  output logic         o_busy,
  output logic         o_err
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_WAIT   = 3'd2,
    ST_STREAM = 3'd3,
    ST_DRAIN  = 3'd4,
    ST_ERR    = 3'd5
  } state_t;

  state_t        state_reg, state_next;
  logic [255:0]  key_reg, key_next;
  logic [95:0]   non_reg, non_next;
  logic [31:0]   cnt_reg, cnt_next;
  logic [3:0]    idx_reg, idx_next;
  logic          err_reg, err_next;

  logic          out_valid_reg, out_valid_next;
  logic [31:0]   out_data_reg, out_data_next;
  logic [3:0]    out_keep_reg, out_keep_next;
  logic          out_last_reg, out_last_next;

  // Keystream block, word k in element k (matches i_blk_stream bit order).
  logic [15:0][31:0] ks_buf_reg;
  logic              ks_load;

  logic [31:0]   ks_word;
  logic [31:0]   keep_mask;
  logic          in_ready;
  logic          in_accept;

  // Byte-enable expansion: bytes that are not kept leave the block as zero.
  for (genvar gi = 0; gi < 4; gi++) begin : g_keep_mask
    assign keep_mask[8*gi +: 8] = {8{i_keep[gi]}};
  end

  assign ks_word = ks_buf_reg[idx_reg];

  // Input is taken only while streaming and while the single output register
  // is either empty or being emptied this very cycle. This keeps one word per
  // cycle throughput without a second output stage.
  assign in_ready  = (state_reg == ST_STREAM) && (!out_valid_reg || i_out_ready);
  assign in_accept = i_valid && in_ready;

  always_comb begin
    state_next     = state_reg;
    key_next       = key_reg;
    non_next       = non_reg;
    cnt_next       = cnt_reg;
    idx_next       = idx_reg;
    err_next       = err_reg;
    out_valid_next = out_valid_reg;
    out_data_next  = out_data_reg;
    out_keep_next  = out_keep_reg;
    out_last_next  = out_last_reg;
    ks_load        = 1'b0;

    // Output register: load on accept, otherwise release once taken.
    if (in_accept) begin
      out_valid_next = 1'b1;
      out_data_next  = (i_data ^ ks_word) & keep_mask;
      out_keep_next  = i_keep;
      out_last_next  = i_last;
    end else if (i_out_ready) begin
      out_valid_next = 1'b0;
    end

    case (state_reg)
      ST_IDLE: begin
        if (i_init) begin
          key_next   = i_key;
          non_next   = i_non;
          cnt_next   = i_cnt;
          state_next = ST_REQ;
        end
      end

      // o_blk_start is decoded from this state, so it lasts exactly one cycle.
      ST_REQ: begin
        state_next = ST_WAIT;
      end

      ST_WAIT: begin
        if (i_blk_done) begin
          ks_load    = 1'b1;
          idx_next   = 4'd0;
          state_next = ST_STREAM;
        end
      end

      ST_STREAM: begin
        if (in_accept) begin
          idx_next = idx_reg + 4'd1;
          if (i_last) begin
            // Any keystream left in the block is simply dropped.
            state_next = ST_DRAIN;
          end else if (idx_reg == 4'd15) begin
            // Block exhausted. Compare before incrementing so the 32-bit
            // counter can never wrap around onto a used counter value.
            if (cnt_reg == P_CNT_LIMIT) begin
              err_next   = 1'b1;
              state_next = ST_ERR;
            end else begin
              cnt_next   = cnt_reg + 32'd1;
              state_next = ST_REQ;
            end
          end
        end
      end

      ST_DRAIN: begin
        if (!out_valid_reg || i_out_ready) begin
          state_next = ST_IDLE;
        end
      end

      // Terminal until reset; i_init is deliberately ignored here.
      ST_ERR: begin
        state_next = ST_ERR;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg     <= ST_IDLE;
      key_reg       <= '0;
      non_reg       <= '0;
      cnt_reg       <= '0;
      idx_reg       <= '0;
      err_reg       <= 1'b0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_keep_reg  <= '0;
      out_last_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      key_reg       <= key_next;
      non_reg       <= non_next;
      cnt_reg       <= cnt_next;
      idx_reg       <= idx_next;
      err_reg       <= err_next;
      out_valid_reg <= out_valid_next;
      out_data_reg  <= out_data_next;
      out_keep_reg  <= out_keep_next;
      out_last_reg  <= out_last_next;
    end
  end

  // The keystream buffer is only read in STREAM, after it has been loaded in
  // WAIT, so it needs no reset. ks_load is only raised in WAIT, which reset
  // leaves, so a late cc_block result after reset never reaches it.
  always_ff @(posedge i_clk) begin
    if (ks_load) begin
      ks_buf_reg <= i_blk_stream;
    end
  end

  assign o_ready     = in_ready;
  assign o_valid     = out_valid_reg;
  assign o_data      = out_data_reg;
  assign o_keep      = out_keep_reg;
  assign o_last      = out_last_reg;
  assign o_blk_start = (state_reg == ST_REQ);
  assign o_blk_key   = key_reg;
  assign o_blk_non   = non_reg;
  assign o_blk_cnt   = cnt_reg;
  assign o_busy      = (state_reg != ST_IDLE);
  assign o_err       = err_reg;

endmodule

// File: tb/tb_cc_xor_stream.sv
`timescale 1ns/1ps
// Testbench for cc_xor_stream: two instances (default counter limit and
// limit 5) share stimulus; sel5 selects which one the bench is talking to.
// A behavioural cc_block answers each start pulse after a short latency.
module tb_cc_xor_stream;

  localparam int BLK_LAT = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, init0, init5, valid, last, out_ready, blk_done;
  logic [255:0] key;
  logic [95:0]  non;
  logic [31:0]  cnt, data;
  logic [3:0]   keep;
  logic [511:0] blk_stream;

  logic         rdy0, ov0, ol0, st0, busy0, err0;
  logic [31:0]  od0, bc0;
  logic [3:0]   ok0;
  logic [255:0] bk0;
  logic [95:0]  bn0;

  logic         rdy5, ov5, ol5, st5, busy5, err5;
  logic [31:0]  od5, bc5;
  logic [3:0]   ok5;
  logic [255:0] bk5;
  logic [95:0]  bn5;

  logic         sel5, rand_rdy, rfc_mode, blk_manual;
  logic         m_ready, m_valid, m_last, m_start, m_busy, m_err;
  logic [31:0]  m_data, m_blk_cnt;
  logic [3:0]   m_keep;
  logic [255:0] m_blk_key;
  logic [95:0]  m_blk_non;

  assign m_ready   = sel5 ? rdy5 : rdy0;
  assign m_valid   = sel5 ? ov5  : ov0;
  assign m_last    = sel5 ? ol5  : ol0;
  assign m_start   = sel5 ? st5  : st0;
  assign m_busy    = sel5 ? busy5 : busy0;
  assign m_err     = sel5 ? err5 : err0;
  assign m_data    = sel5 ? od5  : od0;
  assign m_blk_cnt = sel5 ? bc5  : bc0;
  assign m_keep    = sel5 ? ok5  : ok0;
  assign m_blk_key = sel5 ? bk5  : bk0;
  assign m_blk_non = sel5 ? bn5  : bn0;

  cc_xor_stream u_dut (
    .i_clk(clk), .i_rst(rst), .i_init(init0), .i_key(key), .i_non(non), .i_cnt(cnt),
    .i_valid(valid), .i_data(data), .i_keep(keep), .i_last(last),
    .o_ready(rdy0), .o_valid(ov0), .o_data(od0), .o_keep(ok0), .o_last(ol0),
    .i_out_ready(out_ready), .o_blk_start(st0), .o_blk_key(bk0), .o_blk_non(bn0),
    .o_blk_cnt(bc0), .i_blk_stream(blk_stream), .i_blk_done(blk_done),
    .o_busy(busy0), .o_err(err0)
  );

  cc_xor_stream #(.P_CNT_LIMIT(32'd5)) u_dut_lim (
    .i_clk(clk), .i_rst(rst), .i_init(init5), .i_key(key), .i_non(non), .i_cnt(cnt),
    .i_valid(valid), .i_data(data), .i_keep(keep), .i_last(last),
    .o_ready(rdy5), .o_valid(ov5), .o_data(od5), .o_keep(ok5), .o_last(ol5),
    .i_out_ready(out_ready), .o_blk_start(st5), .o_blk_key(bk5), .o_blk_non(bn5),
    .o_blk_cnt(bc5), .i_blk_stream(blk_stream), .i_blk_done(blk_done),
    .o_busy(busy5), .o_err(err5)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // RFC 8439 section 2.4.2 plaintext and ciphertext.
  string pt_s = "Ladies and Gentlemen of the class of '99: If I could offer you only one tip for the future, sunscreen would be it.";
  logic [911:0] ct_hex = {
    128'h6e2e359a2568f98041ba0728dd0d6981,
    128'he97e7aec1d4360c20a27afccfd9fae0b,
    128'hf91b65c5524733ab8f593dabcd62b357,
    128'h1639d624e65152ab8f530c359f0861d8,
    128'h07ca0dbf500d6a6156a38e088a22b65e,
    128'h52bc514d16ccf806818ce91ab7793736,
    128'h5af90bbf74a35be6b40b8eedf2785e42,
    16'h874d
  };

  // Bytes past the 114-byte message are filler that must be masked off.
  function automatic logic [7:0] pt_byte(input int i);
    return (i < 114) ? 8'(pt_s[i]) : 8'hab;
  endfunction

  function automatic logic [7:0] ct_byte(input int i);
    return (i < 114) ? ct_hex[911 - 8*i -: 8] : 8'hab;
  endfunction

  function automatic logic [31:0] pt_word(input int w);
    return {pt_byte(4*w+3), pt_byte(4*w+2), pt_byte(4*w+1), pt_byte(4*w)};
  endfunction

  function automatic logic [31:0] ct_word(input int w);
    return {ct_byte(4*w+3), ct_byte(4*w+2), ct_byte(4*w+1), ct_byte(4*w)};
  endfunction

  // RFC keystream recovered as plaintext ^ ciphertext.
  function automatic logic [31:0] ks_rfc_word(input int blk, input int w);
    int b0;
    b0 = 64*blk + 4*w;
    return {pt_byte(b0+3) ^ ct_byte(b0+3), pt_byte(b0+2) ^ ct_byte(b0+2),
            pt_byte(b0+1) ^ ct_byte(b0+1), pt_byte(b0)   ^ ct_byte(b0)};
  endfunction

  // Synthetic keystream: identifies block counter and word index.
  function automatic logic [31:0] syn_ks(input logic [31:0] c, input int w);
    return {c[15:0], 8'h5a, 4'h0, 4'(w)};
  endfunction

  function automatic logic [511:0] make_ks(input logic [31:0] c);
    logic [511:0] s;
    s = '0;
    for (int w = 0; w < 16; w++) begin
      if (rfc_mode) s[32*w +: 32] = (c == 32'd1 || c == 32'd2) ? ks_rfc_word(int'(c) - 1, w) : 32'h0;
      else          s[32*w +: 32] = syn_ks(c, w);
    end
    return s;
  endfunction

  function automatic logic [31:0] mask_of(input logic [3:0] k);
    return {{8{k[3]}}, {8{k[2]}}, {8{k[1]}}, {8{k[0]}}};
  endfunction

  logic [31:0] in_d  [64];
  logic [3:0]  in_k  [64];
  logic [31:0] exp_d [64];
  logic [31:0] rt_d  [64];
  logic [31:0] got_d [$];
  logic [3:0]  got_k [$];
  logic        got_l [$];
  logic [31:0] starts [$];

  // Behavioural cc_block.
  initial begin
    logic [31:0] c;
    blk_done   = 1'b0;
    blk_stream = '0;
    forever begin
      @(negedge clk);
      if (m_start && !blk_manual) begin
        c = m_blk_cnt;
        repeat (BLK_LAT) @(posedge clk);
        #1;
        blk_stream = make_ks(c);
        blk_done   = 1'b1;
        @(posedge clk);
        #1;
        blk_done = 1'b0;
      end
    end
  end

  // Downstream ready: always 1 or random.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output collector and stall-stability checker.
  initial begin
    logic        stall_prev;
    logic [31:0] stall_d;
    logic [3:0]  stall_k;
    logic        stall_l;
    stall_prev = 1'b0;
    stall_d = '0; stall_k = '0; stall_l = 1'b0;
    forever begin
      @(negedge clk);
      if (stall_prev) begin
        check("stall_valid", 256'(m_valid), 256'(1'b1));
        check("stall_data",  256'(m_data),  256'(stall_d));
        check("stall_keep",  256'(m_keep),  256'(stall_k));
        check("stall_last",  256'(m_last),  256'(stall_l));
      end
      if (m_valid && out_ready) begin
        got_d.push_back(m_data);
        got_k.push_back(m_keep);
        got_l.push_back(m_last);
        $display("out w%0d data=%08h keep=%b last=%b", got_d.size() - 1, m_data, m_keep, m_last);
      end
      stall_prev = m_valid && !out_ready;
      stall_d = m_data; stall_k = m_keep; stall_l = m_last;
    end
  end

  // Block-request monitor.
  initial begin
    forever begin
      @(negedge clk);
      if (m_start) begin
        starts.push_back(m_blk_cnt);
        $display("blk start cnt=%0d", m_blk_cnt);
        check("blk_key", m_blk_key, key);
        check("blk_non", 256'(m_blk_non), 256'(non));
      end
    end
  end

  task automatic send_word(input logic [31:0] d, input logic [3:0] k, input logic l, output bit ok);
    int cyc;
    cyc = 0;
    ok  = 1'b0;
    valid = 1'b1; data = d; keep = k; last = l;
    while (cyc < 1000) begin
      @(negedge clk);
      if (m_ready) begin
        ok = 1'b1;
        @(posedge clk);
        #1;
        break;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    valid = 1'b0;
  endtask

  task automatic run_msg(input int n, input bit with_last);
    bit ok;
    int cyc;
    got_d.delete(); got_k.delete(); got_l.delete(); starts.delete();
    @(posedge clk);
    #1;
    if (sel5) init5 = 1'b1; else init0 = 1'b1;
    @(negedge clk);
    check("ready_in_idle", 256'(m_ready), 256'(1'b0));
    @(posedge clk);
    #1;
    init0 = 1'b0; init5 = 1'b0;
    for (int i = 0; i < n; i++) begin
      send_word(in_d[i], in_k[i], with_last && (i == n - 1), ok);
      check($sformatf("accept_w%0d", i), 256'(ok), 256'(1'b1));
      if (!ok) break;
    end
    cyc = 0;
    while (got_d.size() < n && cyc < 3000) begin
      @(posedge clk);
      cyc++;
    end
    check("out_count", 256'(got_d.size()), 256'(n));
    for (int i = 0; i < n && i < got_d.size(); i++) begin
      check($sformatf("w%0d_data", i), 256'(got_d[i]), 256'(exp_d[i]));
      check($sformatf("w%0d_keep", i), 256'(got_k[i]), 256'(in_k[i]));
      check($sformatf("w%0d_last", i), 256'(got_l[i]), 256'(with_last && (i == n - 1)));
    end
    if (with_last) begin
      cyc = 0;
      while (m_busy && cyc < 100) begin
        @(posedge clk);
        cyc++;
      end
      #1;
      check("idle_after_msg", 256'(m_busy), 256'(1'b0));
    end
  endtask

  task automatic fill_rfc(input bit from_rt);
    for (int w = 0; w < 29; w++) begin
      in_k[w]  = (w == 28) ? 4'b0011 : 4'b1111;
      in_d[w]  = from_rt ? rt_d[w] : pt_word(w);
      exp_d[w] = (from_rt ? pt_word(w) : ct_word(w)) & mask_of(in_k[w]);
    end
  endtask

  task automatic fill_syn(input int n, input logic [31:0] c0, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      in_k[i]  = 4'b1111;
      in_d[i]  = base + 32'(i * 32'h01010101);
      exp_d[i] = in_d[i] ^ syn_ks(c0 + 32'(i / 16), i % 16);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    rst = 1'b1; init0 = 1'b0; init5 = 1'b0; valid = 1'b0; last = 1'b0;
    data = '0; keep = '0; sel5 = 1'b0; rand_rdy = 1'b0; rfc_mode = 1'b1; blk_manual = 1'b0;
    for (int k = 0; k < 8; k++) key[32*k +: 32] = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
    non = {32'h0, 32'h4a000000, 32'h0};
    cnt = 32'd1;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    #1;
    check("rst_ready", 256'(rdy0),  256'(1'b0));
    check("rst_valid", 256'(ov0),   256'(1'b0));
    check("rst_start", 256'(st0),   256'(1'b0));
    check("rst_busy",  256'(busy0), 256'(1'b0));
    check("rst_err",   256'(err0),  256'(1'b0));
    check("rst_data",  256'(od0),   256'(32'h0));
    check("rst_keep",  256'(ok0),   256'(4'h0));
    check("rst_last",  256'(ol0),   256'(1'b0));
    check("rst_cnt",   256'(bc0),   256'(32'h0));
    check("rst_key",   bk0,         256'h0);
    check("rst_non",   256'(bn0),   256'h0);
    check("rst_err5",  256'(err5),  256'(1'b0));

    // RFC 8439 vector, downstream always ready
    rfc_mode = 1'b1;
    fill_rfc(1'b0);
    run_msg(29, 1'b1);
    if (got_d.size() >= 29) begin
      check("rfc_word0",  256'(got_d[0]),  256'(32'h9a352e6e));
      check("rfc_word28", 256'(got_d[28]), 256'(32'h00004d87));
      for (int w = 0; w < 29; w++) rt_d[w] = got_d[w];
    end
    check("rfc_starts", 256'(starts.size()), 256'(2));
    if (starts.size() >= 2) begin
      check("rfc_cnt0", 256'(starts[0]), 256'(32'd1));
      check("rfc_cnt1", 256'(starts[1]), 256'(32'd2));
    end

    // Same vector with random downstream back-pressure
    rand_rdy = 1'b1;
    fill_rfc(1'b0);
    run_msg(29, 1'b1);
    rand_rdy = 1'b0;
    repeat (2) @(posedge clk);

    // Round trip: ciphertext back in, plaintext out
    fill_rfc(1'b1);
    run_msg(29, 1'b1);

    // 17 words: two blocks, counters 1 then 2
    rfc_mode = 1'b0;
    key = {8{32'hc001d00d}};
    cnt = 32'd1;
    fill_syn(17, 32'd1, 32'h1000_0000);
    in_d[16]  = 32'h1234_5678;
    exp_d[16] = 32'h1236_0c78;
    run_msg(17, 1'b1);
    check("w17_starts", 256'(starts.size()), 256'(2));
    if (starts.size() >= 2) begin
      check("w17_cnt0", 256'(starts[0]), 256'(32'd1));
      check("w17_cnt1", 256'(starts[1]), 256'(32'd2));
    end

    // Reset while waiting for cc_block; late done must be ignored
    blk_manual = 1'b1;
    cnt = 32'd7;
    @(posedge clk);
    #1;
    init0 = 1'b1;
    @(posedge clk);
    #1;
    init0 = 1'b0;
    check("rw_start", 256'(st0), 256'(1'b1));
    @(posedge clk);
    #1;
    check("rw_busy", 256'(busy0), 256'(1'b1));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    blk_stream = make_ks(32'd7);
    blk_done = 1'b1;
    @(posedge clk);
    #1;
    blk_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rw_idle",  256'(busy0), 256'(1'b0));
    check("rw_valid", 256'(ov0),   256'(1'b0));
    check("rw_ready", 256'(rdy0),  256'(1'b0));
    check("rw_cnt",   256'(bc0),   256'(32'h0));
    blk_manual = 1'b0;
    cnt = 32'd9;
    fill_syn(3, 32'd9, 32'h0bad_f00d);
    run_msg(3, 1'b1);
    check("rw_new_starts", 256'(starts.size()), 256'(1));
    if (starts.size() >= 1) check("rw_new_cnt", 256'(starts[0]), 256'(32'd9));

    // Counter limit 5: 16 words out, then error, no further request
    sel5 = 1'b1;
    cnt  = 32'd5;
    fill_syn(16, 32'd5, 32'ha5a5_0000);
    run_msg(16, 1'b0);
    repeat (BLK_LAT + 4) @(posedge clk);
    #1;
    check("lim_err",    256'(err5),  256'(1'b1));
    check("lim_ready",  256'(rdy5),  256'(1'b0));
    check("lim_busy",   256'(busy5), 256'(1'b1));
    check("lim_starts", 256'(starts.size()), 256'(1));
    valid = 1'b1; data = 32'hffff_0000; keep = 4'hf; last = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m_ready) seen++;
    end
    valid = 1'b0;
    check("lim_no_accept", 256'(seen), 256'(0));
    @(posedge clk);
    #1;
    init5 = 1'b1;
    @(posedge clk);
    #1;
    init5 = 1'b0;
    check("lim_init_ignored", 256'(st5), 256'(1'b0));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("lim_rst_err",  256'(err5),  256'(1'b0));
    check("lim_rst_busy", 256'(busy5), 256'(1'b0));
    sel5 = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
